// File: rtl/game_pkg.sv
// game_pkg -- shared definitions for the game sequencer.
// Holds the FSM state encoding, the default survival-counter width and small
// helpers for evaluating the alive mask.
package game_pkg;

  localparam int SCORE_W_DEFAULT = 16;
  localparam int NUM_PLAYERS     = 4;

  // Encoding is visible on the state output, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_RUN       = 2'd2,
    ST_OVER      = 2'd3
  } state_t;

  // Number of set bits in a 4-bit player mask.
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Index of the single set bit of a one-hot player mask (0 otherwise).
  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// game_sequencer_if -- bundle of the sequencer's game-control signals.
// master: drives tick/start/p_en/dead, observes the game outputs.
// slave : the sequencer itself.
//   tick, start, p_en[3:0], dead[3:0]        -> sequencer
//   in_game[3:0], enable_board, state[1:0],
//   countdown[1:0], winner_valid, winner_id[1:0],
//   draw, score[4*SCORE_W-1:0]               <- sequencer
interface game_sequencer_if
  import game_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEFAULT
);

  logic                 tick;
  logic                 start;
  logic [3:0]           p_en;
  logic [3:0]           dead;
  logic [3:0]           in_game;
  logic                 enable_board;
  logic [1:0]           state;
  logic [1:0]           countdown;
  logic                 winner_valid;
  logic [1:0]           winner_id;
  logic                 draw;
  logic [4*SCORE_W-1:0] score;

  modport master (
    output tick, start, p_en, dead,
    input  in_game, enable_board, state, countdown,
           winner_valid, winner_id, draw, score
  );

  modport slave (
    input  tick, start, p_en, dead,
    output in_game, enable_board, state, countdown,
           winner_valid, winner_id, draw, score
  );

endinterface

// File: rtl/score_counter.sv
// score_counter -- one player's survival counter.
// Ports: clk, reset_n (async, active low), clear (sync clear to 0),
//        inc (count one tick), count[W-1:0] (registered value, saturates).
module score_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Survival counter: clear wins over increment; stops at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer -- start / countdown / run / game-over sequencing for up to
// four players.
// Ports: clk, reset_n (async, active low), bus (game_sequencer_if.slave):
//   inputs tick (80 Hz strobe), start (button level), p_en (enables),
//   dead (per-player dead flags); registered outputs in_game, enable_board,
//   state, countdown, winner_valid, winner_id, draw and the four packed
//   survival scores.
module game_sequencer
  import game_pkg::*;
#(
  parameter int COUNT_TICKS = 80,
  parameter int COUNT_STEPS = 3,
  parameter int SCORE_W     = SCORE_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  game_sequencer_if.slave   bus
);

  localparam int                TICK_W    = (COUNT_TICKS > 1) ? $clog2(COUNT_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(COUNT_TICKS - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [1:0]        STEPS_INIT = 2'(COUNT_STEPS);

  state_t              cur_state, nxt_state;
  logic [3:0]          roster, roster_nxt;
  logic [1:0]          steps_left, steps_nxt;
  logic [TICK_W-1:0]   tick_cnt, tick_nxt;
  logic                board_on, board_nxt;
  logic                win_valid, win_valid_nxt;
  logic [1:0]          win_id, win_id_nxt;
  logic                is_draw, is_draw_nxt;
  logic                start_prev;

  logic                start_edge;
  logic [3:0]          alive;
  logic [2:0]          alive_cnt;
  logic                multi;
  logic                score_clear;
  logic [3:0]          score_inc;
  logic [SCORE_W-1:0]  scores [NUM_PLAYERS];

  assign start_edge = bus.start & ~start_prev;
  // Dead flags of players outside the roster are masked off here.
  assign alive      = roster & ~bus.dead;
  assign alive_cnt  = popcount4(alive);
  assign multi      = (popcount4(roster) >= 3'd2);

  // Start edge detector; previous value resets high so a held button is not a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_prev <= 1'b1;
    end else begin
      start_prev <= bus.start;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_state  <= ST_IDLE;
      roster     <= 4'b0000;
      steps_left <= 2'd0;
      tick_cnt   <= '0;
      board_on   <= 1'b0;
      win_valid  <= 1'b0;
      win_id     <= 2'd0;
      is_draw    <= 1'b0;
    end else begin
      cur_state  <= nxt_state;
      roster     <= roster_nxt;
      steps_left <= steps_nxt;
      tick_cnt   <= tick_nxt;
      board_on   <= board_nxt;
      win_valid  <= win_valid_nxt;
      win_id     <= win_id_nxt;
      is_draw    <= is_draw_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    nxt_state     = cur_state;
    roster_nxt    = roster;
    steps_nxt     = steps_left;
    tick_nxt      = tick_cnt;
    board_nxt     = board_on;
    win_valid_nxt = win_valid;
    win_id_nxt    = win_id;
    is_draw_nxt   = is_draw;
    score_clear   = 1'b0;
    score_inc     = 4'b0000;

    case (cur_state)
      ST_IDLE: begin
        if (start_edge && (bus.p_en != 4'b0000)) begin
          nxt_state   = ST_COUNTDOWN;
          roster_nxt  = bus.p_en;
          steps_nxt   = STEPS_INIT;
          tick_nxt    = '0;
          score_clear = 1'b1;
        end else begin
          nxt_state = ST_IDLE;
        end
      end

      ST_COUNTDOWN: begin
        if (bus.tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_nxt = '0;
            if (steps_left == 2'd1) begin
              nxt_state = ST_RUN;
              steps_nxt = 2'd0;
              board_nxt = 1'b1;
            end else begin
              steps_nxt = steps_left - 2'd1;
            end
          end else begin
            tick_nxt = tick_cnt + TICK_ONE;
          end
        end else begin
          tick_nxt = tick_cnt;
        end
      end

      ST_RUN: begin
        // alive is taken from this cycle's dead flags, so a player dying on
        // a tick cycle misses that tick.
        if (bus.tick) begin
          score_inc = alive;
        end else begin
          score_inc = 4'b0000;
        end
        if (multi) begin
          if (alive_cnt <= 3'd1) begin
            nxt_state     = ST_OVER;
            board_nxt     = 1'b0;
            win_valid_nxt = (alive_cnt == 3'd1);
            win_id_nxt    = onehot_index(alive);
            is_draw_nxt   = (alive_cnt == 3'd0);
          end else begin
            nxt_state = ST_RUN;
          end
        end else begin
          if (alive == 4'b0000) begin
            nxt_state = ST_OVER;
            board_nxt = 1'b0;
          end else begin
            nxt_state = ST_RUN;
          end
        end
      end

      ST_OVER: begin
        // Scores are deliberately kept; they clear at the next game start.
        if (start_edge) begin
          nxt_state     = ST_IDLE;
          roster_nxt    = 4'b0000;
          win_valid_nxt = 1'b0;
          win_id_nxt    = 2'd0;
          is_draw_nxt   = 1'b0;
        end else begin
          nxt_state = ST_OVER;
        end
      end

      default: begin
        nxt_state     = ST_IDLE;
        roster_nxt    = 4'b0000;
        steps_nxt     = 2'd0;
        tick_nxt      = '0;
        board_nxt     = 1'b0;
        win_valid_nxt = 1'b0;
        win_id_nxt    = 2'd0;
        is_draw_nxt   = 1'b0;
      end
    endcase
  end

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_score
    score_counter #(.W(SCORE_W)) u_score (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (score_clear),
      .inc     (score_inc[i]),
      .count   (scores[i])
    );
  end

  assign bus.score        = {scores[3], scores[2], scores[1], scores[0]};
  assign bus.in_game      = roster;
  assign bus.enable_board = board_on;
  assign bus.state        = cur_state;
  assign bus.countdown    = steps_left;
  assign bus.winner_valid = win_valid;
  assign bus.winner_id    = win_id;
  assign bus.draw         = is_draw;

endmodule
